fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It owns the PC, drives fetch requests into the instruction cache through the datapath–cache interface, and registers returned instructions into the IF/ID latch consumed by decode. It also absorbs decode stalls, branch/jump redirects and halt, and never abandons a cache miss already in progress.

---
 rtl/cpu_types_pkg.sv | 4 +
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/ifid_latch.sv | 30 +++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by every pipeline stage.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/fetch_stage_pkg.sv
// Fetch-stage FSM encoding and the IF/ID latch layout.
package fetch_stage_pkg;
   import cpu_types_pkg::*;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic  valid;
      word_t instr;
      word_t pc;
      word_t npc;
   } ifid_t;

   localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: load captures a new entry, flush clears only valid.
module ifid_latch
   import fetch_stage_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  load_i,
   input  logic  flush_i,
   input  ifid_t d_i,
   output ifid_t q_o
);
   ifid_t ifid_q, ifid_d;

   always_comb begin
      ifid_d = ifid_q;
      if (flush_i)
         ifid_d.valid = 1'b0;
      else if (load_i)
         ifid_d = d_i;
   end

   always_ff @(posedge CLK) begin
      if (!nRST)
         ifid_q <= '0;
      else
         ifid_q <= ifid_d;
   end

   assign q_o = ifid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, requests the icache, fills IF/ID.
// Redirects or halts that land during a miss wait in DRAIN for the hit.
module fetch_stage
   import cpu_types_pkg::*;
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
)(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        stall_id,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_npc,
   output logic        halted
);
   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        pend_pc_q, pend_pc_d;
   logic         halt_pend_q, halt_pend_d;
   logic         load, flush, miss;
   word_t        red_tgt;
   ifid_t        ifid_in, ifid_out;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= FETCH;
         pc_q        <= PC_INIT;
         pend_pc_q   <= '0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_pc_q   <= pend_pc_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   assign miss    = imemREN & ~ihit;
   assign red_tgt = redirect_pc & ~32'h3;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_pc_d   = pend_pc_q;
      halt_pend_d = halt_pend_q;
      load        = 1'b0;
      flush       = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (halt) begin
               flush = 1'b1;
               if (miss) begin
                  state_d     = DRAIN;
                  halt_pend_d = 1'b1;
               end else begin
                  state_d = HALTED;
               end
            end else if (redirect) begin
               flush = 1'b1;
               // PC must hold during a miss so the cache completes the original fill
               if (miss) begin
                  state_d   = DRAIN;
                  pend_pc_d = red_tgt;
               end else begin
                  pc_d = red_tgt;
               end
            end else if (stall_id) begin
               load = 1'b0;
            end else if (ihit) begin
               load = 1'b1;
               pc_d = pc_q + PC_STEP;
            end else begin
               flush = 1'b1;
            end
         end
         DRAIN: begin
            flush = 1'b1;
            if (halt)
               halt_pend_d = 1'b1;
            if (redirect)
               pend_pc_d = red_tgt;
            if (ihit) begin
               if (halt || halt_pend_q) begin
                  state_d = HALTED;
               end else begin
                  state_d = FETCH;
                  pc_d    = redirect ? red_tgt : pend_pc_q;
               end
            end
         end
         HALTED: flush = 1'b1;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      imemREN = (state_q != HALTED);
      halted  = (state_q == HALTED);
   end

   assign imemaddr = pc_q;

   assign ifid_in = '{valid: 1'b1, instr: imemload, pc: pc_q, npc: pc_q + PC_STEP};

   ifid_latch u_ifid (
      .CLK     (CLK),
      .nRST    (nRST),
      .load_i  (load),
      .flush_i (flush),
      .d_i     (ifid_in),
      .q_o     (ifid_out)
   );

   assign if_valid = ifid_out.valid;
   assign if_instr = ifid_out.instr;
   assign if_pc    = ifid_out.pc;
   assign if_npc   = ifid_out.npc;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations, checked 1ns after each edge.
module tb_fetch_stage;
   logic        CLK = 1'b0;
   logic        nRST, ihit, stall_id, redirect, halt;
   logic [31:0] imemload, redirect_pc;
   logic        imemREN, if_valid, halted;
   logic [31:0] imemaddr, if_instr, if_pc, if_npc;
   int          checks = 0;
   int          failures = 0;

   always #5 CLK = ~CLK;

   fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr), .stall_id(stall_id),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_npc(if_npc), .halted(halted)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic h, input logic [31:0] ld, input logic st,
                        input logic rd, input logic [31:0] rpc, input logic hl);
      ihit = h; imemload = ld; stall_id = st; redirect = rd; redirect_pc = rpc; halt = hl;
   endtask

   initial begin
      nRST = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("rst_addr",  imemaddr, 32'h0);
      check("rst_ren",   {31'b0, imemREN}, 32'd1);
      check("rst_valid", {31'b0, if_valid}, 32'd0);
      check("rst_halted",{31'b0, halted}, 32'd0);
      check("rst_instr", if_instr, 32'h0);
      check("rst_npc",   if_npc, 32'h0);

      nRST = 1'b1;
      drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("hitA_addr", imemaddr, 32'h4);
      check("hitA_instr", if_instr, 32'hAAAA_0001);
      check("hitA_pc",   if_pc, 32'h0);
      check("hitA_npc",  if_npc, 32'h4);
      check("hitA_valid",{31'b0, if_valid}, 32'd1);
      imemload = 32'hBBBB_0002;
      step();
      check("hitB_addr", imemaddr, 32'h8);
      check("hitB_instr", if_instr, 32'hBBBB_0002);
      check("hitB_pc",   if_pc, 32'h4);
      imemload = 32'hCCCC_0003;
      step();
      check("hitC_addr", imemaddr, 32'hC);
      check("hitC_instr", if_instr, 32'hCCCC_0003);
      check("hitC_pc",   if_pc, 32'h8);
      check("hitC_valid",{31'b0, if_valid}, 32'd1);
      imemload = 32'hDDDD_0004;
      step();
      check("hitD_addr", imemaddr, 32'h10);

      // stall at PC=0x10 with a hit present: everything holds
      drive(1'b1, 32'hEEEE_0005, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_addr",  imemaddr, 32'h10);
         check("stall_instr", if_instr, 32'hDDDD_0004);
         check("stall_pc",    if_pc, 32'hC);
         check("stall_valid", {31'b0, if_valid}, 32'd1);
         check("stall_ren",   {31'b0, imemREN}, 32'd1);
      end
      stall_id = 1'b0;
      step();
      check("unstall_addr",  imemaddr, 32'h14);
      check("unstall_instr", if_instr, 32'hEEEE_0005);
      check("unstall_pc",    if_pc, 32'h10);

      // redirect beats stall; low bits of target ignored
      drive(1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_0043, 1'b0);
      step();
      check("redir_addr",  imemaddr, 32'h40);
      check("redir_valid", {31'b0, if_valid}, 32'd0);

      drive(1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h20, 1'b0);
      step();
      check("redir20_addr", imemaddr, 32'h20);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("bubble_addr",  imemaddr, 32'h20);
      check("bubble_valid", {31'b0, if_valid}, 32'd0);

      // redirect during a miss: drain the fill at 0x20 first
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0);
      step();
      check("drain0_addr", imemaddr, 32'h20);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("drain_addr",  imemaddr, 32'h20);
         check("drain_ren",   {31'b0, imemREN}, 32'd1);
         check("drain_valid", {31'b0, if_valid}, 32'd0);
      end
      drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("drainhit_addr",  imemaddr, 32'h80);
      check("drainhit_valid", {31'b0, if_valid}, 32'd0);
      imemload = 32'h4444_4444;
      step();
      check("post_drain_addr",  imemaddr, 32'h84);
      check("post_drain_instr", if_instr, 32'h4444_4444);
      check("post_drain_pc",    if_pc, 32'h80);
      check("post_drain_valid", {31'b0, if_valid}, 32'd1);

      // halt during a miss at 0x30
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h30, 1'b0);
      step();
      check("to30_addr", imemaddr, 32'h30);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      step();
      check("hmiss_ren",    {31'b0, imemREN}, 32'd1);
      check("hmiss_halted", {31'b0, halted}, 32'd0);
      halt = 1'b0;
      step();
      check("hmiss2_ren",   {31'b0, imemREN}, 32'd1);
      check("hmiss2_addr",  imemaddr, 32'h30);
      ihit = 1'b1;
      step();
      check("halted",       {31'b0, halted}, 32'd1);
      check("halted_ren",   {31'b0, imemREN}, 32'd0);
      check("halted_valid", {31'b0, if_valid}, 32'd0);
      check("halted_addr",  imemaddr, 32'h30);
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
      step();
      check("halted_ign_addr", imemaddr, 32'h30);
      check("halted_ign_flag", {31'b0, halted}, 32'd1);

      // reset out of HALTED, then reset while in DRAIN
      nRST = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("rst2_halted", {31'b0, halted}, 32'd0);
      check("rst2_addr",   imemaddr, 32'h0);
      nRST = 1'b1;
      drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("rst2_hit_addr", imemaddr, 32'h4);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0);
      step();
      check("drain2_addr", imemaddr, 32'h4);
      nRST = 1'b0;
      redirect = 1'b0;
      step();
      check("rstdrain_addr",  imemaddr, 32'h0);
      check("rstdrain_valid", {31'b0, if_valid}, 32'd0);
      check("rstdrain_ren",   {31'b0, imemREN}, 32'd1);
      nRST = 1'b1;
      drive(1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("rstdrain_fetch_addr",  imemaddr, 32'h4);
      check("rstdrain_fetch_instr", if_instr, 32'h6666_6666);
      check("rstdrain_fetch_valid", {31'b0, if_valid}, 32'd1);

      // halt with no miss: immediate, beats the hit
      drive(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0, 1'b1);
      step();
      check("halt_nomiss_flag",  {31'b0, halted}, 32'd1);
      check("halt_nomiss_addr",  imemaddr, 32'h4);
      check("halt_nomiss_valid", {31'b0, if_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
